tcp_tx_scheduler: RTL and testbench
===================================

TCP_TX_SCHEDULER -- requirements
Module: tcp_tx_scheduler

Interface
REQ-001 Parameter N_REQ, default 4, SHALL set the number of TCP requesters sharing one tcp_packet_generator (range 2..8).
REQ-002 Parameter TIMEOUT_CYCLES, default 4096, SHALL set the maximum SEND duration before abort.
REQ-003 The clock is i_clk; i_rst_n is asynchronous, active-low reset; the block SHALL use one clock only.
REQ-004 i_clk  in  1  clock.
REQ-005 i_rst_n  in  1  async active-low reset.
REQ-006 i_req  in  N_REQ  per-requester send request, level, held until o_done or o_timeout for that requester.
REQ-007 i_req_hdr  in  N_REQ x tcp_hdr_t  per-requester header fields (seq, ack, src/dst port, flags, window, src/dst IP).
REQ-008 o_grant  out  N_REQ  one-hot owner of the generator; all-zero when idle.
REQ-009 o_done  out  N_REQ  one-cycle pulse: the granted packet completed.
REQ-010 o_timeout  out  N_REQ  one-cycle pulse: the granted packet was aborted.
REQ-011 o_gen_hdr  out  tcp_hdr_t  header fields to the generator.
REQ-012 o_gen_hdr_valid  out  1  header valid to the generator.
REQ-013 i_gen_packet_done  in  1  packet-done pulse from the generator.
REQ-014 o_busy  out  1  high in any state other than IDLE.

Function
REQ-015 The FSM SHALL have the states IDLE, SEND and GAP.
REQ-016 IDLE: when any i_req bit is high, the FSM SHALL select a requester round-robin, starting from the index after the last-served one, latch its index and i_req_hdr, and enter SEND on the next edge.
REQ-017 The latched header SHALL be used for the whole packet; requester field changes after latch SHALL be ignored.
REQ-018 SEND: o_gen_hdr_valid=1, o_gen_hdr=latched header, o_grant=one-hot(latched index).
REQ-019 SEND: i_gen_packet_done=1 SHALL move the FSM to GAP and flag completion.
REQ-020 SEND: a timer cleared on SEND entry SHALL increment every cycle; when it reaches TIMEOUT_CYCLES-1 without done, the FSM SHALL move to GAP and flag abort.
REQ-021 If done and timeout occur in the same cycle, done SHALL win and o_timeout SHALL NOT pulse.
REQ-022 GAP, lasting exactly 1 cycle: o_gen_hdr_valid=0, o_grant=0, and either o_done[idx] or o_timeout[idx] pulses; the last-served pointer SHALL update to idx; then the FSM returns to IDLE.
REQ-023 The minimum spacing from one SEND entry to the next SHALL be 3 cycles (SEND>=1, GAP, IDLE).
REQ-024 Deasserting i_req[idx] during SEND SHALL NOT abort the packet; o_done still pulses.
REQ-025 i_gen_packet_done in IDLE or GAP SHALL be ignored.
REQ-026 With a single persistent requester, that requester SHALL be re-granted every packet; with all requesters active, grants SHALL rotate 0,1,...,N_REQ-1,0.
REQ-027 o_gen_hdr_valid SHALL never be high in IDLE, so the generator cannot start a second packet from a stale header.

Reset
REQ-028 On i_rst_n=0 (asynchronous): state=IDLE, timer=0, last-served pointer=N_REQ-1 (requester 0 first), latched header=0, all outputs 0.
REQ-029 Reset asserted mid-SEND SHALL drop o_gen_hdr_valid and o_grant immediately with no o_done/o_timeout pulse; the first grant after release SHALL go to the lowest-index active requester.

Structure
REQ-030 Package tcp_sched_pkg SHALL hold tcp_hdr_t (184-bit packed struct), the FSM state enum, and the default N_REQ and TIMEOUT_CYCLES.
REQ-031 Round-robin selection SHALL be a combinational sub-module rr_arbiter (inputs: request vector and last pointer; outputs: valid and index), reusable by other network_processor schedulers.
REQ-032 All outputs except o_busy SHALL be driven from registered state and a registered header, with no input-to-output combinational path other than the FSM decode.

Verification
REQ-033 Single request: i_req=0001 with seq=0x11223344 and generator done after 20 cycles -> o_grant=0001 for 20 cycles, o_gen_hdr.seq=0x11223344, o_done=0001 for one cycle.
REQ-034 All requesters active continuously for 8 packets -> grant order 0,1,2,3,0,1,2,3 and no overlapping grants.
REQ-035 Generator never signals done -> o_timeout[idx] pulses once after 4096 SEND cycles, and the next requester is granted.
REQ-036 Requester 2 drops i_req and changes its header mid-SEND -> o_gen_hdr stays at the latched value and o_done=0100 pulses.
REQ-037 Reset pulled low 5 cycles into SEND with requesters 1 and 3 active -> outputs are 0 asynchronously; after release requester 1 is granted first.
REQ-038 Done arrives on cycle TIMEOUT_CYCLES-1 -> o_done pulses and o_timeout stays 0.

Source files
------------

// File: rtl/tcp_tx_scheduler_pkg.sv
// Shared types for the TCP transmit scheduler: header bundle,
// FSM state encoding and default sizing.
package tcp_sched_pkg;

    localparam int N_REQ_DEF   = 4;
    localparam int TIMEOUT_DEF = 4096;

    // 184-bit header handed to the packet generator
    typedef struct packed {
        logic [31:0] seq;
        logic [31:0] ack;
        logic [15:0] src_port;
        logic [15:0] dst_port;
        logic [7:0]  flags;
        logic [15:0] window;
        logic [31:0] src_ip;
        logic [31:0] dst_ip;
    } tcp_hdr_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_GAP  = 2'd2
    } sched_state_e;

endpackage

// File: rtl/tcp_tx_scheduler_if.sv
// Scheduler-to-generator link.
// hdr/hdr_valid: header offer; packet_done: completion pulse back.
interface tcp_gen_if;
    import tcp_sched_pkg::*;

    tcp_hdr_t hdr;
    logic     hdr_valid;
    logic     packet_done;

    modport master (
        output hdr,
        output hdr_valid,
        input  packet_done
    );

    modport slave (
        input  hdr,
        input  hdr_valid,
        output packet_done
    );

endinterface

// File: rtl/tcp_tx_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first set req bit after 'last'.
// Ports: req (vector), last (pointer) -> valid, idx.
module rr_arbiter #(
    parameter int N = 4
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] last,
    output logic                 valid,
    output logic [$clog2(N)-1:0] idx
);

    localparam int IW = $clog2(N);

    // Scan farthest-to-nearest so the nearest hit after 'last' wins.
    always_comb begin
        int c;
        c     = 0;
        valid = 1'b0;
        idx   = '0;
        for (int k = N; k >= 1; k--) begin
            c = (int'(last) + k) % N;
            if (req[c]) begin
                valid = 1'b1;
                idx   = IW'(c);
            end
        end
    end

endmodule

// File: rtl/tcp_tx_scheduler.sv
// Shares one TCP packet generator among N_REQ requesters.
// Ports: i_clk, i_rst_n, i_req/i_req_hdr in, o_grant/o_done/
// o_timeout/o_busy out, gen (master side of the generator link).
module tcp_tx_scheduler
    import tcp_sched_pkg::*;
#(
    parameter int N_REQ          = N_REQ_DEF,
    parameter int TIMEOUT_CYCLES = TIMEOUT_DEF
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic [N_REQ-1:0]     i_req,
    input  tcp_hdr_t [N_REQ-1:0] i_req_hdr,
    output logic [N_REQ-1:0]     o_grant,
    output logic [N_REQ-1:0]     o_done,
    output logic [N_REQ-1:0]     o_timeout,
    output logic                 o_busy,
    tcp_gen_if.master            gen
);

    localparam int IW = $clog2(N_REQ);
    localparam int TW = $clog2(TIMEOUT_CYCLES);

    sched_state_e   state_q, state_d;
    logic [IW-1:0]  idx_q;
    logic [IW-1:0]  last_q;
    tcp_hdr_t       hdr_q;
    logic [TW-1:0]  timer_q;
    logic           done_q;

    logic           arb_valid;
    logic [IW-1:0]  arb_idx;
    logic           tmo_hit;
    logic [N_REQ-1:0] idx_oh;
    logic           hdr_valid;

    rr_arbiter #(.N(N_REQ)) u_arb (
        .req   (i_req),
        .last  (last_q),
        .valid (arb_valid),
        .idx   (arb_idx)
    );

    assign tmo_hit = (timer_q == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (arb_valid) state_d = ST_SEND;
            ST_SEND: if (gen.packet_done || tmo_hit) state_d = ST_GAP;
            ST_GAP:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Owner, header, timer and outcome; last-served moves in GAP.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            idx_q   <= '0;
            last_q  <= IW'(N_REQ - 1);
            hdr_q   <= '0;
            timer_q <= '0;
            done_q  <= 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    timer_q <= '0;
                    done_q  <= 1'b0;
                    if (arb_valid) begin
                        idx_q <= arb_idx;
                        hdr_q <= i_req_hdr[arb_idx];
                    end
                end
                ST_SEND: begin
                    timer_q <= timer_q + TW'(1);
                    // done beats a coincident timeout
                    done_q  <= gen.packet_done;
                end
                ST_GAP:  last_q <= idx_q;
                default: ;
            endcase
        end
    end

    always_comb begin
        idx_oh        = '0;
        idx_oh[idx_q] = 1'b1;
        o_grant       = '0;
        o_done        = '0;
        o_timeout     = '0;
        hdr_valid     = 1'b0;
        unique case (state_q)
            ST_SEND: begin
                o_grant   = idx_oh;
                hdr_valid = 1'b1;
            end
            ST_GAP: begin
                if (done_q) o_done    = idx_oh;
                else        o_timeout = idx_oh;
            end
            default: ;
        endcase
    end

    assign gen.hdr       = hdr_q;
    assign gen.hdr_valid = hdr_valid;
    assign o_busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_tcp_tx_scheduler.sv
// Scoreboard bench for tcp_tx_scheduler: randomized rounds,
// timeout, done-at-limit and asynchronous reset cases.
module tb_tcp_tx_scheduler;
    import tcp_sched_pkg::*;

    localparam int N = 4;
    localparam int T = 4096;

    typedef struct {
        int       idx;
        tcp_hdr_t hdr;
        bit       ok;
        int       len;
    } exp_t;

    typedef struct {
        int d;
        bit mod;
    } plan_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [N-1:0] req = '0;
    tcp_hdr_t [N-1:0] req_hdr = '0;
    logic [N-1:0] grant, done, tmo;
    logic busy;

    tcp_gen_if gen_if ();

    tcp_tx_scheduler #(.N_REQ(N), .TIMEOUT_CYCLES(T)) dut (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .i_req     (req),
        .i_req_hdr (req_hdr),
        .o_grant   (grant),
        .o_done    (done),
        .o_timeout (tmo),
        .o_busy    (busy),
        .gen       (gen_if.master)
    );

    always #5 clk = ~clk;

    exp_t  sb[$];
    plan_t plan[$];
    int vectors = 0;
    int errors  = 0;
    bit mon_en  = 1'b0;
    int last_srv = N - 1;
    int n_issued = 0;
    int n_compl  = 0;
    bit r_busy = 1'b0;
    int r_cnt = 0;
    plan_t r_p;

    task automatic chk(input string nm, input logic [255:0] act,
                       input logic [255:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     nm, act, exp, $time);
        end
    endtask

    function automatic tcp_hdr_t rand_hdr();
        tcp_hdr_t h;
        h.seq      = $urandom();
        h.ack      = $urandom();
        h.src_port = 16'($urandom());
        h.dst_port = 16'($urandom());
        h.flags    = 8'($urandom());
        h.window   = 16'($urandom());
        h.src_ip   = $urandom();
        h.dst_ip   = $urandom();
        return h;
    endfunction

    function automatic int oh_idx(input logic [N-1:0] v);
        int r;
        r = 0;
        for (int i = 0; i < N; i++) if (v[i]) r = i;
        return r;
    endfunction

    // Requesters and generator model; one call per clock.
    task automatic tick();
        @(negedge clk);
        if ((done | tmo) != '0) n_compl++;
        for (int i = 0; i < N; i++)
            if (done[i] | tmo[i]) req[i] = 1'b0;
        gen_if.packet_done = 1'b0;
        if (grant != '0) begin
            if (!r_busy) begin
                r_busy = 1'b1;
                r_cnt  = 0;
                r_p    = '{0, 1'b0};
                if (plan.size() != 0) r_p = plan.pop_front();
                if (r_p.mod) begin
                    req[oh_idx(grant)]     = 1'b0;
                    req_hdr[oh_idx(grant)] = rand_hdr();
                end
            end
            r_cnt++;
            if (r_p.d != 0 && r_cnt == r_p.d) gen_if.packet_done = 1'b1;
        end else begin
            r_busy = 1'b0;
            gen_if.packet_done = ($urandom_range(0, 7) == 0);
        end
    endtask

    // Raise 'mask' at once; expected order is the next active
    // index after the last-served one, repeatedly.
    task automatic run_round(input logic [N-1:0] mask, input int d_first,
                             input int mod_mode, input bit keep_hdr);
        logic [N-1:0] m;
        int n;
        int budget;
        m = mask;
        n = 0;
        for (int i = 0; i < N; i++)
            if (mask[i] && !keep_hdr) req_hdr[i] = rand_hdr();
        while (m != '0) begin
            int c;
            int d;
            bit md;
            c = -1;
            for (int k = 1; k <= N; k++) begin
                int j;
                j = (last_srv + k) % N;
                if (c < 0 && m[j]) c = j;
            end
            m[c] = 1'b0;
            last_srv = c;
            d = (n == 0 && d_first >= 0) ? d_first : $urandom_range(1, 40);
            md = (mod_mode == 1) ||
                 (mod_mode == 2 && $urandom_range(0, 2) == 0);
            plan.push_back('{d, md});
            sb.push_back('{c, req_hdr[c], (d >= 1 && d <= T),
                           (d >= 1 && d <= T) ? d : T});
            n++;
        end
        n_issued += n;
        req = req | mask;
        budget = n * (T + 10) + 20;
        while (n_compl < n_issued && budget > 0) begin
            tick();
            budget--;
        end
        if (budget == 0) begin
            vectors++;
            errors++;
            $display("FAIL round_wait: got %0d completions expected %0d",
                     n_compl, n_issued);
        end
        tick();
    endtask

    // Monitor: pops expectations when grants and completions appear.
    exp_t m_exp;
    bit m_in = 1'b0;
    int m_len = 0;
    logic [N-1:0] m_eg;

    always @(negedge clk) begin
        if (!mon_en) begin
            m_in = 1'b0;
        end else if (grant != '0) begin
            chk("grant_onehot", $onehot(grant), 1);
            chk("busy_in_send", busy, 1);
            if (!m_in) begin
                m_in  = 1'b1;
                m_len = 0;
                if (sb.size() == 0) begin
                    chk("unexpected_grant", grant, 0);
                    m_exp = '{0, '0, 1'b0, 0};
                end else begin
                    m_exp = sb.pop_front();
                    m_eg = '0;
                    m_eg[m_exp.idx] = 1'b1;
                    chk("grant_idx", grant, m_eg);
                end
            end
            m_len++;
            chk("hdr_valid_send", gen_if.hdr_valid, 1);
            chk("gen_hdr", gen_if.hdr, m_exp.hdr);
        end else begin
            chk("hdr_valid_idle", gen_if.hdr_valid, 0);
            if ((done | tmo) != '0) begin
                if (!m_in) begin
                    chk("stray_done", done, 0);
                    chk("stray_timeout", tmo, 0);
                end else begin
                    m_eg = '0;
                    m_eg[m_exp.idx] = 1'b1;
                    chk("done_vec", done, m_exp.ok ? m_eg : '0);
                    chk("timeout_vec", tmo, m_exp.ok ? '0 : m_eg);
                    chk("send_len", m_len, m_exp.len);
                    m_in = 1'b0;
                end
            end
        end
    end

    initial begin
        int budget;
        gen_if.packet_done = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_grant", grant, 0);
        chk("rst_done", done, 0);
        chk("rst_timeout", tmo, 0);
        chk("rst_busy", busy, 0);
        chk("rst_valid", gen_if.hdr_valid, 0);
        chk("rst_hdr", gen_if.hdr, 0);
        rst_n = 1'b1;
        mon_en = 1'b1;
        tick();

        run_round(4'b1111, -1, 0, 0);
        run_round(4'b1111, -1, 0, 0);

        req_hdr[0] = rand_hdr();
        req_hdr[0].seq = 32'h1122_3344;
        run_round(4'b0001, 20, 0, 1);

        run_round(4'b0100, 15, 1, 0);
        run_round(4'b0011, 0, 0, 0);
        run_round(4'b0001, T, 0, 0);

        for (int r = 0; r < 40; r++)
            run_round(4'($urandom_range(1, 15)), -1, 2, 0);

        repeat (3) tick();
        chk("sb_drained", sb.size(), 0);
        mon_en = 1'b0;

        plan.delete();
        repeat (3) plan.push_back('{0, 1'b0});
        req_hdr[1] = rand_hdr();
        req_hdr[3] = rand_hdr();
        req = 4'b1010;
        budget = 20;
        while (grant == '0 && budget > 0) begin
            tick();
            budget--;
        end
        chk("pre_rst_grant", grant != '0, 1);
        repeat (5) tick();
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_grant", grant, 0);
        chk("async_rst_valid", gen_if.hdr_valid, 0);
        chk("async_rst_done", done, 0);
        chk("async_rst_timeout", tmo, 0);
        chk("async_rst_busy", busy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        r_busy = 1'b0;
        plan.delete();
        repeat (3) plan.push_back('{0, 1'b0});
        budget = 20;
        while (grant == '0 && budget > 0) begin
            tick();
            budget--;
        end
        chk("post_rst_first_grant", grant, 4'b0010);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, errors);
        $finish;
    end

endmodule
